// File: rtl/pe_coef_unpacker.sv
// pe_coef_unpacker: ByteDecode_d stage, unpacks an LSB-first 32-bit word stream into NUM d-bit
// coefficients per beat, 256 per polynomial. Define PE_UNPACK_RANGE_CHK_EN for the d==12 range check.
module pe_coef_unpacker #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int Q     = 3329
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           d_sel,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM*WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err_range
);
  localparam int BEATS = 256 / NUM;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((256 % NUM) != 0 || NUM * 12 > 48 || Q < 2 || Q > 4095) begin : g_bad_params
    $error("pe_coef_unpacker: unsupported NUM or Q");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    d_reg;
  logic [63:0]   bit_buf_reg, bit_buf_next;
  logic [6:0]    cnt_reg, cnt_next;
  logic [6:0]    words_reg;
  logic [BW-1:0] beat_reg;

  logic       d_legal, start_accept, in_fire, out_fire;
  logic [6:0] beat_bits, cnt_base;
  logic [63:0] buf_shift;
  logic [11:0] coef_mask;

  always_comb begin
    d_legal = 1'b0;
    case (d_sel)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_legal = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end

  assign beat_bits    = 7'(NUM) * {3'b000, d_reg};
  assign start_accept = (state_reg == IDLE) && start && d_legal;
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;

  // Every output below is decoded from registered state only.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE: if (start_accept) state_next = RUN;
      RUN: begin
        in_ready  = (cnt_reg <= 7'd32) && (words_reg < {d_reg, 3'b000});
        out_valid = (cnt_reg >= beat_bits);
        out_last  = out_valid && (beat_reg == BW'(BEATS - 1));
        if (out_valid && out_ready && out_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Consume first, then append the new word right above the surviving bits.
  always_comb begin
    buf_shift    = out_fire ? (bit_buf_reg >> beat_bits) : bit_buf_reg;
    cnt_base     = out_fire ? (cnt_reg - beat_bits) : cnt_reg;
    bit_buf_next = buf_shift;
    cnt_next     = cnt_base;
    if (in_fire) begin
      bit_buf_next = buf_shift | ({32'b0, in_data} << cnt_base);
      cnt_next     = cnt_base + 7'd32;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      d_reg       <= '0;
      bit_buf_reg <= '0;
      cnt_reg     <= '0;
      words_reg   <= '0;
      beat_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        d_reg       <= d_sel;
        bit_buf_reg <= '0;
        cnt_reg     <= '0;
        words_reg   <= '0;
        beat_reg    <= '0;
      end else begin
        bit_buf_reg <= bit_buf_next;
        cnt_reg     <= cnt_next;
        if (in_fire)  words_reg <= words_reg + 7'd1;
        if (out_fire) beat_reg  <= beat_reg + BW'(1);
      end
    end
  end

  assign coef_mask = 12'((13'd1 << d_reg) - 13'd1);

  logic [NUM-1:0] lane_bad;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
    logic [11:0] coef;
    assign coef = 12'(bit_buf_reg >> (7'(gi) * {3'b000, d_reg})) & coef_mask;
    assign out_data[gi*WIDTH +: WIDTH] = WIDTH'(coef);
`ifdef PE_UNPACK_RANGE_CHK_EN
    assign lane_bad[gi] = (coef >= 12'(Q));
`else
    assign lane_bad[gi] = 1'b0;
`endif
  end

`ifdef PE_UNPACK_RANGE_CHK_EN
  logic err_range_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_range_reg <= 1'b0;
    end else if (start_accept) begin
      err_range_reg <= 1'b0;
    end else if (out_fire && (d_reg == 4'd12) && (|lane_bad)) begin
      err_range_reg <= 1'b1;
    end
  end

  assign err_range = err_range_reg;
`else
  // Lane flags are constant zero here; fold them in so nothing is left dangling.
  assign err_range = |lane_bad;
`endif

endmodule
